// File: rtl/led_counter_ctrl.sv
// Run-control sequencer for the LED counter: prescaled BITS-wide counter with start/stop/clear/load.
// Define LED_COUNTER_CTRL_BOUNCE_EN for ping-pong counting with an internal direction register.
module led_counter_ctrl #(
    parameter int unsigned BITS      = 16,
    parameter int unsigned LOG2DELAY = 22
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            stop,
    input  logic            clear,
    input  logic            load,
    input  logic [BITS-1:0] load_val,
    input  logic            dir,
    output logic [BITS-1:0] led,
    output logic            running,
    output logic            tick,
    output logic            dir_o
);

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t               state;
    state_t               state_next;
    logic [LOG2DELAY-1:0] pre;
    logic                 step;
    logic [BITS-1:0]      cnt_step;

    // load never blocks stop/start; clear blocks everything
    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = IDLE;
        end else if (stop) begin
            if (state == RUN) state_next = HOLD;
        end else if (start && (state != RUN)) begin
            state_next = RUN;
        end
    end

    assign step = (state == RUN) && (pre == '1);

`ifdef LED_COUNTER_CTRL_BOUNCE_EN
    logic dir_step;
    logic unused_dir;

    assign unused_dir = dir;

    // Reflect at either end instead of wrapping
    always_comb begin
        cnt_step = led;
        dir_step = dir_o;
        if (!dir_o) begin
            if (led == '1) begin
                cnt_step = led - 1'b1;
                dir_step = 1'b1;
            end else begin
                cnt_step = led + 1'b1;
            end
        end else begin
            if (led == '0) begin
                cnt_step = BITS'(1);
                dir_step = 1'b0;
            end else begin
                cnt_step = led - 1'b1;
            end
        end
    end
`else
    assign dir_o = dir;

    always_comb begin
        cnt_step = dir_o ? (led - 1'b1) : (led + 1'b1);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pre     <= '0;
            led     <= '0;
            running <= 1'b0;
            tick    <= 1'b0;
`ifdef LED_COUNTER_CTRL_BOUNCE_EN
            dir_o   <= 1'b0;
`endif
        end else begin
            state   <= state_next;
            running <= (state_next == RUN);
            tick    <= 1'b0;
            if (clear) begin
                led <= '0;
                pre <= '0;
`ifdef LED_COUNTER_CTRL_BOUNCE_EN
                dir_o <= 1'b0;
`endif
            end else if (load) begin
                led <= load_val;
                pre <= '0;
            end else if (state == RUN) begin
                // prescaler advances on the current state, so it still counts in a stop cycle
                pre <= pre + 1'b1;
                if (step) begin
                    led  <= cnt_step;
                    tick <= 1'b1;
`ifdef LED_COUNTER_CTRL_BOUNCE_EN
                    dir_o <= dir_step;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_led_counter_ctrl.sv
// Table-driven self-checking bench for led_counter_ctrl with BITS=4, LOG2DELAY=2.
// Each vector drives one clock of commands and checks the outputs just after that edge.
module tb_led_counter_ctrl;

    typedef struct {
        logic       start;
        logic       stop;
        logic       clear;
        logic       load;
        logic [3:0] load_val;
        logic       dir;
        logic [3:0] exp_led;
        logic       exp_running;
        logic       exp_tick;
        logic       exp_dir_o;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       clear;
    logic       load;
    logic [3:0] load_val;
    logic       dir;
    logic [3:0] led;
    logic       running;
    logic       tick;
    logic       dir_o;

    int unsigned n_checks;
    int unsigned n_fail;
    vec_t        vq[$];

    led_counter_ctrl #(
        .BITS      (4),
        .LOG2DELAY (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .clear    (clear),
        .load     (load),
        .load_val (load_val),
        .dir      (dir),
        .led      (led),
        .running  (running),
        .tick     (tick),
        .dir_o    (dir_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic s, input logic p, input logic c, input logic l,
                       input logic [3:0] lv, input logic d, input logic [3:0] e_led,
                       input logic e_run, input logic e_tick, input logic e_dir);
        vec_t v;
        v.start = s; v.stop = p; v.clear = c; v.load = l; v.load_val = lv; v.dir = d;
        v.exp_led = e_led; v.exp_running = e_run; v.exp_tick = e_tick; v.exp_dir_o = e_dir;
        vq.push_back(v);
    endtask

    // n idle cycles with constant expected outputs
    task automatic idle(input int n, input logic d, input logic [3:0] e_led,
                        input logic e_run, input logic e_dir);
        for (int i = 0; i < n; i++) add(0, 0, 0, 0, 4'h0, d, e_led, e_run, 1'b0, e_dir);
    endtask

    task automatic check_outputs(input int idx, input logic [3:0] e_led, input logic e_run,
                                 input logic e_tick, input logic e_dir);
        check("led", idx, led, e_led);
        check("running", idx, {3'b0, running}, {3'b0, e_run});
        check("tick", idx, {3'b0, tick}, {3'b0, e_tick});
        check("dir_o", idx, {3'b0, dir_o}, {3'b0, e_dir});
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; load = 1'b0;
        load_val = 4'h0; dir = 1'b0;

`ifndef LED_COUNTER_CTRL_BOUNCE_EN
        add(1, 0, 0, 0, 4'h0, 0, 4'h0, 1, 0, 0);        // start
        idle(3, 0, 4'h0, 1, 0);
        add(0, 0, 0, 0, 4'h0, 0, 4'h1, 1, 1, 0);        // first step 4 cycles after entry
        idle(3, 0, 4'h1, 1, 0);
        add(0, 0, 0, 0, 4'h0, 0, 4'h2, 1, 1, 0);
        idle(1, 0, 4'h2, 1, 0);
        add(0, 1, 0, 0, 4'h0, 0, 4'h2, 0, 0, 0);        // stop, prescaler frozen at 2
        idle(20, 0, 4'h2, 0, 0);
        add(1, 0, 0, 0, 4'h0, 0, 4'h2, 1, 0, 0);        // resume
        idle(1, 0, 4'h2, 1, 0);
        add(0, 0, 0, 0, 4'h0, 0, 4'h3, 1, 1, 0);        // step 2 cycles after resume
        idle(1, 0, 4'h3, 1, 0);
        add(0, 1, 0, 0, 4'h0, 0, 4'h3, 0, 0, 0);
        add(0, 0, 0, 1, 4'hE, 0, 4'hE, 0, 0, 0);        // load in HOLD
        add(1, 0, 0, 0, 4'h0, 0, 4'hE, 1, 0, 0);
        idle(3, 0, 4'hE, 1, 0);
        add(0, 0, 0, 0, 4'h0, 0, 4'hF, 1, 1, 0);
        idle(3, 0, 4'hF, 1, 0);
        add(0, 0, 0, 0, 4'h0, 0, 4'h0, 1, 1, 0);        // up wrap
        idle(3, 0, 4'h0, 1, 0);
        add(0, 0, 0, 0, 4'h0, 0, 4'h1, 1, 1, 0);
        idle(1, 0, 4'h1, 1, 0);
        add(0, 0, 0, 1, 4'h0, 1, 4'h0, 1, 0, 1);        // load 0 while running, count down
        idle(3, 1, 4'h0, 1, 1);
        add(0, 0, 0, 0, 4'h0, 1, 4'hF, 1, 1, 1);        // down wrap
        idle(3, 1, 4'hF, 1, 1);
        add(0, 0, 0, 0, 4'h0, 1, 4'hE, 1, 1, 1);
        idle(3, 1, 4'hE, 1, 1);
`else
        add(0, 0, 0, 1, 4'hE, 1, 4'hE, 0, 0, 0);        // dir input ignored throughout
        add(1, 0, 0, 0, 4'h0, 1, 4'hE, 1, 0, 0);
        idle(3, 1, 4'hE, 1, 0);
        add(0, 0, 0, 0, 4'h0, 1, 4'hF, 1, 1, 0);
        idle(3, 1, 4'hF, 1, 0);
        add(0, 0, 0, 0, 4'h0, 1, 4'hE, 1, 1, 1);        // reflect at top
        idle(3, 1, 4'hE, 1, 1);
        add(0, 0, 0, 0, 4'h0, 1, 4'hD, 1, 1, 1);
        add(0, 0, 0, 1, 4'h1, 0, 4'h1, 1, 0, 1);        // load keeps direction
        idle(3, 0, 4'h1, 1, 1);
        add(0, 0, 0, 0, 4'h0, 0, 4'h0, 1, 1, 1);
        idle(3, 0, 4'h0, 1, 1);
        add(0, 0, 0, 0, 4'h0, 0, 4'h1, 1, 1, 0);        // reflect at bottom
        idle(3, 0, 4'h1, 1, 0);
`endif
        // clear+load+start on a would-be step cycle: clear wins, no tick
        add(1, 0, 1, 1, 4'h5, 0, 4'h0, 0, 0, 0);
        idle(1, 0, 4'h0, 0, 0);
        add(0, 0, 0, 1, 4'h7, 0, 4'h7, 0, 0, 0);
        add(1, 0, 0, 0, 4'h0, 0, 4'h7, 1, 0, 0);
        idle(2, 0, 4'h7, 1, 0);

        repeat (2) @(posedge clk);
        #1;
        check_outputs(-1, 4'h0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            start = vq[i].start; stop = vq[i].stop; clear = vq[i].clear;
            load = vq[i].load; load_val = vq[i].load_val; dir = vq[i].dir;
            @(posedge clk);
            #1;
            check_outputs(i, vq[i].exp_led, vq[i].exp_running, vq[i].exp_tick, vq[i].exp_dir_o);
        end
        start = 1'b0; stop = 1'b0; clear = 1'b0; load = 1'b0; load_val = 4'h0; dir = 1'b0;

        // async reset mid-interval, checked before any further clock edge
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs(-2, 4'h0, 1'b0, 1'b0, 1'b0);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_outputs(-3, 4'h0, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
